// File: rtl/lmem_pkg.sv
// Shared definitions for the layer-memory port arbiter: state codes,
// memory-select codes, default widths and the select legality check.
package lmem_pkg;

    localparam int AW_DEF   = 12;
    localparam int DW_DEF   = 20;
    localparam int SELW_DEF = 3;

    // Arbiter FSM state codes
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] OWN0 = 2'd1;
    localparam logic [1:0] OWN1 = 2'd2;

    // csel codes of the memories behind the port
    localparam logic [SELW_DEF-1:0] L0_K0   = 3'd1;
    localparam logic [SELW_DEF-1:0] L0_K1   = 3'd2;
    localparam logic [SELW_DEF-1:0] L1_K0   = 3'd3;
    localparam logic [SELW_DEF-1:0] L1_K1   = 3'd4;
    localparam logic [SELW_DEF-1:0] L2_FLAT = 3'd5;

    // True when sel names one of the existing memories
    function automatic logic sel_legal(input logic [SELW_DEF-1:0] sel);
        logic ok;
        case (sel)
            L0_K0, L0_K1, L1_K0, L1_K1, L2_FLAT: ok = 1'b1;
            default:                             ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/lmem_port_arbiter_if.sv
// Requester handshakes plus the shared layer-memory port.
// master = requesters and memory, slave = the arbiter.
interface lmem_port_arbiter_if #(
    parameter int AW   = 12,
    parameter int DW   = 20,
    parameter int SELW = 3
);
    logic            req0, req1, last0, last1, we0, we1;
    logic [SELW-1:0] sel0, sel1;
    logic [AW-1:0]   addr0, addr1;
    logic [DW-1:0]   wdata0, wdata1;
    logic            gnt0, gnt1, rvalid0, rvalid1, err;
    logic [DW-1:0]   rdata;
    logic            cwr, crd;
    logic [SELW-1:0] csel;
    logic [AW-1:0]   caddr_wr, caddr_rd;
    logic [DW-1:0]   cdata_wr, cdata_rd;

    modport master (
        output req0, req1, last0, last1, we0, we1, sel0, sel1,
               addr0, addr1, wdata0, wdata1, cdata_rd,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, err,
               cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
    );

    modport slave (
        input  req0, req1, last0, last1, we0, we1, sel0, sel1,
               addr0, addr1, wdata0, wdata1, cdata_rd,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, err,
               cwr, crd, csel, caddr_wr, caddr_rd, cdata_wr
    );
endinterface

// File: rtl/lmem_rr_pick.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to rr.
module lmem_rr_pick (
    input  logic req0_i,
    input  logic req1_i,
    input  logic rr_i,
    output logic pick_o
);
    assign pick_o = (req0_i && req1_i) ? rr_i : req1_i;
endmodule

// File: rtl/lmem_port_arbiter.sv
// Round-robin burst arbiter for the shared layer-memory port. Commands
// are registered; read data is steered back to the issuing requester.
module lmem_port_arbiter
    import lmem_pkg::*;
#(
    parameter int AW        = AW_DEF,
    parameter int DW        = DW_DEF,
    parameter int SELW      = SELW_DEF,
    parameter int MAX_BURST = 16
) (
    input  logic               clk,
    input  logic               reset,
    lmem_port_arbiter_if.slave bus
);
    localparam int CW = $clog2(MAX_BURST);

    logic [1:0]      state_q, state_d;
    logic            rr_q, rr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pick, owning, own, own_req, own_last, oth_req;
    logic            acc, burst_end;
    logic            b_we, b_legal;
    logic [SELW-1:0] b_sel;
    logic [AW-1:0]   b_addr;
    logic [DW-1:0]   b_wdata;

    logic            cwr_q, crd_q, err_q, pend_own_q, rvalid0_q, rvalid1_q;
    logic [SELW-1:0] csel_q;
    logic [AW-1:0]   caddr_wr_q, caddr_rd_q;
    logic [DW-1:0]   cdata_wr_q;

    lmem_rr_pick u_pick (
        .req0_i (bus.req0),
        .req1_i (bus.req1),
        .rr_i   (rr_q),
        .pick_o (pick)
    );

    // Owner-relative view of the two requesters
    assign owning    = (state_q == OWN0) || (state_q == OWN1);
    assign own       = (state_q == OWN1);
    assign own_req   = own ? bus.req1  : bus.req0;
    assign own_last  = own ? bus.last1 : bus.last0;
    assign oth_req   = own ? bus.req0  : bus.req1;
    assign acc       = owning && own_req;
    // A dropped request ends the burst without a beat
    assign burst_end = owning && (!own_req || own_last || (cnt_q == CW'(MAX_BURST - 1)));

    assign b_we    = own ? bus.we1    : bus.we0;
    assign b_sel   = own ? bus.sel1   : bus.sel0;
    assign b_addr  = own ? bus.addr1  : bus.addr0;
    assign b_wdata = own ? bus.wdata1 : bus.wdata0;
    assign b_legal = sel_legal(b_sel);

    // Next owner, round-robin pointer and beat count
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        if (owning) begin
            if (burst_end) begin
                rr_d  = ~own;
                cnt_d = '0;
                if (oth_req)      state_d = own ? OWN0 : OWN1;
                else if (own_req) state_d = state_q;
                else              state_d = IDLE;
            end else if (acc) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (bus.req0 || bus.req1) begin
            state_d = pick ? OWN1 : OWN0;
        end else begin
            state_d = IDLE;
        end
    end

    // FSM, round-robin pointer and beat counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            rr_q    <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Registered memory command; illegal selects are consumed without strobes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cwr_q      <= 1'b0;
            crd_q      <= 1'b0;
            csel_q     <= '0;
            caddr_wr_q <= '0;
            caddr_rd_q <= '0;
            cdata_wr_q <= '0;
            err_q      <= 1'b0;
            pend_own_q <= 1'b0;
        end else begin
            cwr_q <= acc && b_we && b_legal;
            crd_q <= acc && !b_we && b_legal;
            if (acc) begin
                csel_q     <= b_sel;
                pend_own_q <= own;
                if (b_we) begin
                    caddr_wr_q <= b_addr;
                    cdata_wr_q <= b_wdata;
                end else begin
                    caddr_rd_q <= b_addr;
                end
                if (!b_legal) err_q <= 1'b1;
            end
        end
    end

    // Read return: memory answers the cycle after crd, flag the issuer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
        end else begin
            rvalid0_q <= crd_q && !pend_own_q;
            rvalid1_q <= crd_q && pend_own_q;
        end
    end

    assign bus.gnt0     = (state_q == OWN0);
    assign bus.gnt1     = (state_q == OWN1);
    assign bus.cwr      = cwr_q;
    assign bus.crd      = crd_q;
    assign bus.csel     = csel_q;
    assign bus.caddr_wr = caddr_wr_q;
    assign bus.caddr_rd = caddr_rd_q;
    assign bus.cdata_wr = cdata_wr_q;
    assign bus.err      = err_q;
    assign bus.rvalid0  = rvalid0_q;
    assign bus.rvalid1  = rvalid1_q;
    assign bus.rdata    = (rvalid0_q || rvalid1_q) ? bus.cdata_rd : '0;
endmodule

// File: doc/lmem_port_arbiter.md
# lmem_port_arbiter

Two-requester arbiter for the single shared layer-memory port (cwr/crd/csel/caddr_wr/caddr_rd/cdata_wr/cdata_rd) behind the CNN engine. It lets the convolution engine (requester 0) and the host readback/debug path (requester 1) share the port in round-robin bursts. It registers every memory command and steers one-cycle-latency read data back to the requester that issued the read.

## Interface
- AW, 12, layer-memory address width
- DW, 20, data width
- SELW, 3, memory select width
- MAX_BURST, 16, max beats per grant; power of two, ≥2

- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- req0 / req1  in  1  requester k wants a beat this cycle
- last0 / last1  in  1  this beat ends requester k's burst
- we0 / we1  in  1  1 = write beat, 0 = read beat
- sel0 / sel1  in  SELW  target memory (csel code)
- addr0 / addr1  in  AW  beat address
- wdata0 / wdata1  in  DW  write data
- gnt0 / gnt1  out  1  requester k owns the port; a beat is accepted when reqk & gntk
- rvalid0 / rvalid1  out  1  read data for requester k is on rdata
- rdata  out  DW  returned read data
- err  out  1  sticky flag: an accepted beat had an illegal select
- cwr, crd  out  1  memory write / read strobes
- csel  out  SELW  memory select
- caddr_wr, caddr_rd  out  AW  write / read address
- cdata_wr  out  DW  write data
- cdata_rd  in  DW  memory read data, valid the cycle after crd

## Operation
- FSM states: IDLE, OWN0, OWN1. gntk = (state == OWNk), decoded from the state register with no input dependence.
- IDLE:
  - If exactly one request is high, go to that requester's OWN state.
  - If both are high, go to OWN[rr], where rr is the round-robin pointer.
  - With no requests, stay in IDLE.
- OWNk:
  - Each accepted beat increments beat_cnt.
  - The burst ends when an accepted beat has lastk=1, when beat_cnt == MAX_BURST-1 on an accepted beat, or when reqk is low in any OWNk cycle (release; no beat).
  - At burst end, rr ← other requester.
  - Next state: OWN[other] if the other requester's req is high, else OWNk if reqk is high on a lastk/MAX_BURST end, else IDLE. beat_cnt ← 0.
- Accepted beat:
  - Write: cwr←1, crd←0, caddr_wr←addr, cdata_wr←wdata, csel←sel.
  - Read: crd←1, cwr←0, caddr_rd←addr, csel←sel; record owner k in a one-deep pending register.
  - Cycles with no accepted beat: cwr←0 and crd←0. Addresses, csel and cdata_wr hold their values.
- Illegal select is sel == 0 or sel > 5. The beat is accepted and counted but drops both strobes. err←1 and stays set until reset.
- Read return: the cycle after crd=1, rdata←cdata_rd and rvalid[owner]←1 for one cycle. rvalid of the other requester stays 0.
- Requesters hold req/we/sel/addr/wdata stable until the beat is accepted.

## Timing
- Reset values:
  - state=IDLE, rr=0, beat_cnt=0.
  - gnt0 = gnt1 = 0.
  - cwr = crd = 0, csel = 0, caddr_wr = caddr_rd = 0, cdata_wr = 0.
  - rvalid0 = rvalid1 = 0, rdata = 0, err = 0.
- Grant latency from IDLE: req rises at edge N, gnt visible after edge N+1.
- Switch between owners: zero bubble. The first beat of the new owner can be accepted in the cycle immediately after the old owner's final beat.
- Command latency: a beat accepted at edge N drives cwr/crd during cycle N+1 (registered).
- Read data latency: rvalid/rdata valid during cycle N+2 for a read accepted at edge N.
- Throughput: one beat per cycle, back-to-back reads pipelined.
- Reset mid-burst: everything returns to reset values immediately (async). A pending rvalid is discarded, never delivered.

## Structure
- Shared package lmem_pkg:
  - state enum {IDLE, OWN0, OWN1}.
  - csel codes: L0_K0=1, L0_K1=2, L1_K0=3, L1_K1=4, L2_FLAT=5.
  - AW/DW/SELW defaults.
  - Function sel_legal().
- One sub-module, lmem_rr_pick: a two-way round-robin pick from (req0, req1, rr) to the chosen owner. The FSM, beat counter and return pipe stay in the top module.

## Test plan
- Single write: req0=1, we0=1, sel0=1, addr0=0x040, wdata0=0x00ABC, last0=1 → gnt0 after 1 edge; cwr=1, csel=1, caddr_wr=0x040, cdata_wr=0x00ABC for one cycle; then IDLE.
- Contention: req0 and req1 rise together from reset → OWN0 first (rr=0). Requester 0 does a 3-beat burst with last on beat 3; OWN1 follows with no idle cycle.
- Burst cap: req0 held with last0=0 for 40 beats while req1=1 → gnt0 for exactly 16 accepted beats, then gnt1.
- Read return: requester 1 reads sel=3 at addrs 0x010, 0x011, 0x012 back-to-back with the memory model returning 0x11111, 0x22222, 0x33333 → rvalid1 on three consecutive cycles with those values; rvalid0 stays 0.
- Illegal select: write with sel0=6 → no cwr pulse, err=1 and stays 1 through later legal beats.
- Reset mid-burst: assert reset while a read is accepted → the next cycle shows crd=0, rvalid=0, gnt=0, err=0.
